rf_wb_queue: RTL and testbench

//  Write-side front end of the register file: accepts results from the ALU and load paths,

---
 rtl/rf_wb_queue.sv | 106 ++++++++++
 tb/tb_rf_wb_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_queue.sv
// Register-file write-side queue: merges load/ALU results into an in-order FIFO that drives
// one RF write per cycle, and exposes a pending-write scoreboard for decode hazard stalls.
module rf_wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ld_vld,
  input  logic [3:0]                 ld_addr,
  input  logic [15:0]                ld_data,
  output logic                       ld_rdy,
  input  logic                       alu_vld,
  input  logic [3:0]                 alu_addr,
  input  logic [15:0]                alu_data,
  output logic                       alu_rdy,
  input  logic                       flush,
  input  logic [3:0]                 q0_addr,
  input  logic [3:0]                 q1_addr,
  output logic                       q0_pend,
  output logic                       q1_pend,
  output logic [3:0]                 dst_addr,
  output logic [15:0]                dst,
  output logic                       we,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PW-1:0]   alu_wr_ptr;
  logic [CW-1:0]   free;
  logic [CW-1:0]   n_push;
  logic            ld_push, alu_push, pop;

  // Readiness depends on registered occupancy only, so there is no vld->rdy path.
  assign free    = CW'(DEPTH) - count;
  assign ld_rdy  = (free >= CW'(1));
  assign alu_rdy = (free >= CW'(2));

  // Writes to r0 complete the handshake but never occupy a slot.
  assign ld_push  = ld_vld  & ld_rdy  & (ld_addr  != 4'd0) & ~flush;
  assign alu_push = alu_vld & alu_rdy & (alu_addr != 4'd0) & ~flush;
  assign pop      = (count != '0);

  assign n_push     = CW'(ld_push) + CW'(alu_push);
  assign alu_wr_ptr = wr_ptr_q + PW'(ld_push);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (ld_push)  mem_q[wr_ptr_q]   <= '{addr: ld_addr,  data: ld_data};
      if (alu_push) mem_q[alu_wr_ptr] <= '{addr: alu_addr, data: alu_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count    <= '0;
      we       <= 1'b0;
      dst_addr <= 4'd0;
      dst      <= 16'd0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count    <= '0;
      we       <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(n_push);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      count    <= count + n_push - CW'(pop);
      we       <= pop;
      if (pop) begin
        dst_addr <= mem_q[rd_ptr_q].addr;
        dst      <= mem_q[rd_ptr_q].data;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PW-1:0] offset;
    q0_pend = 1'b0;
    q1_pend = 1'b0;
    offset  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      offset = PW'(i) - rd_ptr_q;
      if ({1'b0, offset} < count) begin
        if (mem_q[i].addr == q0_addr) q0_pend = 1'b1;
        if (mem_q[i].addr == q1_addr) q1_pend = 1'b1;
      end
    end
    if (we && (dst_addr == q0_addr)) q0_pend = 1'b1;
    if (we && (dst_addr == q1_addr)) q1_pend = 1'b1;
    if (q0_addr == 4'd0) q0_pend = 1'b0;
    if (q1_addr == 4'd0) q1_pend = 1'b0;
  end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: vector table for ready/occupancy plus a write-order
// scoreboard and hand-written latency, flush and reset sequences.
module tb_rf_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n, ld_vld, alu_vld, flush;
  logic [3:0]  ld_addr, alu_addr, q0_addr, q1_addr;
  logic [15:0] ld_data, alu_data;
  logic        ld_rdy, alu_rdy, q0_pend, q1_pend, we;
  logic [3:0]  dst_addr;
  logic [15:0] dst;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  logic [19:0] exp_q[$];

  rf_wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_data(ld_data), .ld_rdy(ld_rdy),
    .alu_vld(alu_vld), .alu_addr(alu_addr), .alu_data(alu_data), .alu_rdy(alu_rdy),
    .flush(flush), .q0_addr(q0_addr), .q1_addr(q1_addr), .q0_pend(q0_pend), .q1_pend(q1_pend),
    .dst_addr(dst_addr), .dst(dst), .we(we), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Record accepted transfers, advance one edge, then retire any write against the model.
  task automatic step();
    logic la, aa;
    logic [19:0] e;
    la = ld_vld && ld_rdy;
    aa = alu_vld && alu_rdy;
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (la && ld_addr != 4'd0)  exp_q.push_back({ld_addr, ld_data});
      if (aa && alu_addr != 4'd0) exp_q.push_back({alu_addr, alu_data});
    end
    @(posedge clk);
    #1;
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", {12'd0, dst_addr, dst}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write_order", {12'd0, dst_addr, dst}, {12'd0, e});
      end
    end
  endtask

  task automatic idle();
    ld_vld = 1'b0; alu_vld = 1'b0; flush = 1'b0;
  endtask

  typedef struct {
    logic       lv;
    logic [3:0] la;
    logic       av;
    logic [3:0] aa;
    logic       e_ldr;
    logic       e_alr;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 4'd5, 1'b0, 4'd0,  1'b1, 1'b1, 3'd1};
    vecs[1] = '{1'b1, 4'd2, 1'b1, 4'd2,  1'b1, 1'b1, 3'd2};
    vecs[2] = '{1'b0, 4'd0, 1'b1, 4'd3,  1'b1, 1'b1, 3'd2};
    vecs[3] = '{1'b1, 4'd4, 1'b1, 4'd6,  1'b1, 1'b1, 3'd3};
    vecs[4] = '{1'b1, 4'd7, 1'b1, 4'd8,  1'b1, 1'b0, 3'd3};
    vecs[5] = '{1'b0, 4'd0, 1'b1, 4'd9,  1'b1, 1'b0, 3'd2};
    vecs[6] = '{1'b0, 4'd0, 1'b1, 4'd0,  1'b1, 1'b1, 3'd1};
    vecs[7] = '{1'b1, 4'd0, 1'b1, 4'd10, 1'b1, 1'b1, 3'd1};
    vecs[8] = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b1, 1'b1, 3'd0};
    vecs[9] = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b1, 1'b1, 3'd0};

    rst_n = 1'b0; idle();
    ld_addr = 4'd0; ld_data = 16'd0; alu_addr = 4'd0; alu_data = 16'd0;
    q0_addr = 4'd0; q1_addr = 4'd0;
    step(); step();
    rst_n = 1'b1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_dst", {12'd0, dst_addr, dst}, 32'd0);
    chk("reset_rdy", {30'd0, ld_rdy, alu_rdy}, 32'd3);
    q0_addr = 4'd5;
    chk("reset_pend", {30'd0, q0_pend, q1_pend}, 32'd0);

    // Single load latency and scoreboard window.
    ld_vld = 1'b1; ld_addr = 4'd5; ld_data = 16'hA5A5;
    step(); idle();
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_we_n", 32'(we), 32'd0);
    chk("t1_pend_queued", 32'(q0_pend), 32'd1);
    step();
    chk("t1_we", {15'd0, we, dst_addr, dst}, {15'd0, 1'b1, 4'd5, 16'hA5A5});
    chk("t1_pend_port", 32'(q0_pend), 32'd1);
    step();
    chk("t1_we_off", 32'(we), 32'd0);
    chk("t1_pend_off", 32'(q0_pend), 32'd0);

    // Same-cycle load and ALU to one register retire load first.
    ld_vld = 1'b1; ld_addr = 4'd2; ld_data = 16'h1111;
    alu_vld = 1'b1; alu_addr = 4'd2; alu_data = 16'h2222;
    q0_addr = 4'd2; q1_addr = 4'd3;
    step(); idle();
    chk("t2_count", 32'(count), 32'd2);
    chk("t2_pend", {30'd0, q0_pend, q1_pend}, 32'd2);
    step();
    chk("t2_first", {15'd0, we, dst_addr, dst}, {15'd0, 1'b1, 4'd2, 16'h1111});
    step();
    chk("t2_second", {15'd0, we, dst_addr, dst}, {15'd0, 1'b1, 4'd2, 16'h2222});
    chk("t2_pend_port", 32'(q0_pend), 32'd1);
    step();
    chk("t2_pend_off", {30'd0, q0_pend, we}, 32'd0);

    // Vector table: readiness before the edge, occupancy after it.
    for (int i = 0; i < 10; i++) begin
      ld_vld = vecs[i].lv;  ld_addr = vecs[i].la;  ld_data = 16'h1000 + 16'(i);
      alu_vld = vecs[i].av; alu_addr = vecs[i].aa;
      alu_data = (vecs[i].aa == 4'd0) ? 16'hFFFF : 16'h2000 + 16'(i);
      q0_addr = 4'd0;
      chk($sformatf("vec%0d_rdy", i), {30'd0, ld_rdy, alu_rdy},
          {30'd0, vecs[i].e_ldr, vecs[i].e_alr});
      step();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_pend_r0", i), 32'(q0_pend), 32'd0);
    end
    idle();
    chk("vec_drained", 32'(exp_q.size()), 32'd0);

    // r0 write is swallowed.
    alu_vld = 1'b1; alu_addr = 4'd0; alu_data = 16'hFFFF;
    step(); idle();
    chk("t4_count", 32'(count), 32'd0);
    step();
    chk("t4_we", {31'd0, we}, 32'd0);

    // Flush with three entries queued drops everything, including that cycle's load.
    ld_vld = 1'b1; ld_addr = 4'd3; ld_data = 16'h3333;
    alu_vld = 1'b1; alu_addr = 4'd4; alu_data = 16'h4444;
    step();
    ld_addr = 4'd5; ld_data = 16'h5555; alu_addr = 4'd6; alu_data = 16'h6666;
    step();
    chk("t5_count_full", 32'(count), 32'd3);
    alu_vld = 1'b0; ld_addr = 4'd7; ld_data = 16'h7777; flush = 1'b1;
    q0_addr = 4'd5; q1_addr = 4'd7;
    chk("t5_rdy_preflush", {30'd0, ld_rdy, alu_rdy}, 32'd2);
    step(); idle();
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_we", {31'd0, we}, 32'd0);
    chk("t5_pend", {30'd0, q0_pend, q1_pend}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_write", {31'd0, we}, 32'd0);
    end

    // Reset in mid-flight.
    ld_vld = 1'b1; ld_addr = 4'd8; ld_data = 16'h8888;
    alu_vld = 1'b1; alu_addr = 4'd9; alu_data = 16'h9999;
    step();
    alu_vld = 1'b0; ld_addr = 4'd10; ld_data = 16'hAAAA;
    step(); idle();
    chk("t6_pre", {29'd0, we, count[1:0]}, {29'd0, 1'b1, 2'd2});
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_we", {31'd0, we}, 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_dst", {12'd0, dst_addr, dst}, 32'd0);
    chk("t6_rdy", {30'd0, ld_rdy, alu_rdy}, 32'd3);
    step();
    chk("t6_quiet", {31'd0, we}, 32'd0);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
